m_axi_wr: RTL

M_AXI_WR -- requirements
Module: m_axi_wr

---
 rtl/m_axi_wr.sv | 120 ++++++++++++
 1 files changed

// File: rtl/m_axi_wr.sv
// rtl/m_axi_wr.sv - AXI4 write-burst master (AW, W, B); wr_err output under `M_AXI_WR_BRESP_CHK_EN
module m_axi_wr #(
  parameter int C_M_AXI_ID_WIDTH     = 1,
  parameter int C_M_AXI_ADDR_WIDTH   = 32,
  parameter int C_M_AXI_DATA_WIDTH   = 32,
  parameter int C_M_AXI_AWUSER_WIDTH = 1,
  parameter int C_M_AXI_WUSER_WIDTH  = 1,
  parameter int C_M_AXI_BUSER_WIDTH  = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     wr_addr,
  input  logic [7:0]                        wr_len,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     wr_data,
  output logic                              wr_req,
  output logic                              wr_done,
  output logic                              wr_busy,
  output logic [C_M_AXI_ID_WIDTH-1:0]       axi_awid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     axi_awaddr,
  output logic [7:0]                        axi_awlen,
  output logic [2:0]                        axi_awsize,
  output logic [1:0]                        axi_awburst,
  output logic                              axi_awlock,
  output logic [3:0]                        axi_awcache,
  output logic [2:0]                        axi_awprot,
  output logic [3:0]                        axi_awqos,
  output logic [C_M_AXI_AWUSER_WIDTH-1:0]   axi_awuser,
  output logic                              axi_awvalid,
  input  logic                              axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   axi_wstrb,
  output logic                              axi_wlast,
  output logic [C_M_AXI_WUSER_WIDTH-1:0]    axi_wuser,
  output logic                              axi_wvalid,
  input  logic                              axi_wready,
  input  logic [C_M_AXI_ID_WIDTH-1:0]       axi_bid,
  input  logic [1:0]                        axi_bresp,
  input  logic [C_M_AXI_BUSER_WIDTH-1:0]    axi_buser,
  input  logic                              axi_bvalid,
`ifdef M_AXI_WR_BRESP_CHK_EN
  output logic                              wr_err,
`endif
  output logic                              axi_bready
);

  localparam logic [2:0] AW_SIZE = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));

  typedef enum logic [1:0] {IDLE, W_ADDR, W_DATA, W_RESP} state_t;

  state_t     state, state_nx;
  logic [7:0] beat_cnt;
  logic       start_ok;
  logic       w_hs;

  assign start_ok = (state == IDLE) && wr_start;
  assign w_hs     = axi_wvalid && axi_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      axi_awaddr  <= '0;
      axi_awlen   <= '0;
      axi_awvalid <= 1'b0;
      beat_cnt    <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        axi_awaddr  <= wr_addr;
        axi_awlen   <= wr_len - 8'd1;
        axi_awvalid <= 1'b1;
        beat_cnt    <= '0;
      end else begin
        if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
        // Hold at awlen on the last beat so a 256-beat burst never wraps to 0.
        if (w_hs && !axi_wlast) beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (wr_start)                state_nx = W_ADDR;
      W_ADDR:  if (axi_awready)             state_nx = W_DATA;
      W_DATA:  if (axi_wready && axi_wlast) state_nx = W_RESP;
      W_RESP:  if (axi_bvalid)              state_nx = IDLE;
      default:                              state_nx = IDLE;
    endcase
  end

  assign axi_awid    = '0;
  assign axi_awsize  = AW_SIZE;
  assign axi_awburst = 2'b01;
  assign axi_awlock  = 1'b0;
  assign axi_awcache = 4'b0010;
  assign axi_awprot  = 3'b000;
  assign axi_awqos   = 4'b0000;
  assign axi_awuser  = '1;
  assign axi_wstrb   = '1;
  assign axi_wuser   = '0;

  assign axi_wvalid  = (state == W_DATA);
  assign axi_wdata   = wr_data;
  assign axi_wlast   = axi_wvalid && (beat_cnt == axi_awlen);
  assign axi_bready  = (state == W_RESP);
  assign wr_req      = w_hs;
  assign wr_done     = axi_bvalid && axi_bready;
  assign wr_busy     = (state != IDLE);

`ifdef M_AXI_WR_BRESP_CHK_EN
  assign wr_err = wr_done && (axi_bresp != 2'b00);
  logic unused_b;
  assign unused_b = ^{axi_bid, axi_buser};
`else
  logic unused_b;
  assign unused_b = ^{axi_bid, axi_buser, axi_bresp};
`endif

endmodule
